// File: rtl/receptor_serial_pkg.sv
// receptor_serial_pkg
// Shared definitions for the serial link receiver (and its transmitter twin):
//   COMMA        - idle/comma byte, the pattern used for byte alignment
//   align_state_e - alignment FSM encodings HUNT / CHECK / LOCKED
//   data_width_e  - dataS codes selecting the packed output width
//   lastIndex()   - final byte index of a packed word for a given width
package receptor_serial_pkg;

    localparam logic [7:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    typedef enum logic [1:0] {
        WIDTH_8    = 2'b00,
        WIDTH_16   = 2'b01,
        WIDTH_32   = 2'b10,
        WIDTH_RSVD = 2'b11
    } data_width_e;

    // Index of the last byte in a word; 0 means "no packing" (8-bit and
    // the reserved code both behave as plain byte output).
    function automatic logic [1:0] lastIndex(input data_width_e width);
        case (width)
            WIDTH_16: lastIndex = 2'd1;
            WIDTH_32: lastIndex = 2'd3;
            default:  lastIndex = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/receptor_serial_if.sv
// receptor_serial_if
// Bundles the receiver's stream input and its received-data outputs.
//   enb, serialIn, dataS                 - driven by the upstream/control side
//   locked, K, dataOut, valid8,
//   dataOut16, valid16, dataOut32, valid32 - driven by the receiver
// master: the side feeding the receiver and consuming its outputs.
// slave:  the receiver itself.
interface receptor_serial_if;

    logic        enb;
    logic        serialIn;
    logic [1:0]  dataS;
    logic        locked;
    logic        K;
    logic [7:0]  dataOut;
    logic        valid8;
    logic [15:0] dataOut16;
    logic        valid16;
    logic [31:0] dataOut32;
    logic        valid32;

    modport master (
        output enb, serialIn, dataS,
        input  locked, K, dataOut, valid8, dataOut16, valid16, dataOut32, valid32
    );

    modport slave (
        input  enb, serialIn, dataS,
        output locked, K, dataOut, valid8, dataOut16, valid16, dataOut32, valid32
    );

endinterface

// File: rtl/receptor_serial_alinea_byte.sv
// alinea_byte
// Serial-to-byte front end: shifter, bit counter and the HUNT/CHECK/LOCKED
// alignment FSM.
//   clk, rst      - clock and synchronous active-high reset
//   enb_i         - enable; low freezes every register here
//   serial_i      - serial bit stream, MSB first
//   dropLock_i    - forces the FSM back to HUNT (gap limit hit upstream)
//   rxByte_o      - last completed byte (valid while byteStrobe_o is high)
//   isComma_o     - rxByte_o equals COMMA
//   byteStrobe_o  - a byte completed while locked and has not been consumed
//   locked_o      - FSM is in LOCKED
module alinea_byte
    import receptor_serial_pkg::*;
#(
    parameter logic [7:0] COMMA       = receptor_serial_pkg::COMMA,
    parameter int         LOCK_COMMAS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb_i,
    input  logic       serial_i,
    input  logic       dropLock_i,
    output logic [7:0] rxByte_o,
    output logic       isComma_o,
    output logic       byteStrobe_o,
    output logic       locked_o
);

    align_state_e state_q, state_d;
    logic [7:0]   shift_q, shift_d;
    logic [2:0]   bitCnt_q, bitCnt_d;
    logic [7:0]   commaCnt_q, commaCnt_d;
    logic         strobe_q;
    logic         byteDone;
    logic         windowIsComma;

    // The window including the bit arriving on this edge; alignment decisions
    // are made on it so that the byte boundary lands exactly on this edge.
    assign shift_d       = {shift_q[6:0], serial_i};
    assign windowIsComma = (shift_d == COMMA);
    assign byteDone      = (bitCnt_q == 3'd7);

    // State register: FSM, shifter and counters all freeze while enb_i is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            shift_q    <= 8'h00;
            bitCnt_q   <= 3'd0;
            commaCnt_q <= 8'd0;
        end else if (enb_i) begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitCnt_q   <= bitCnt_d;
            commaCnt_q <= commaCnt_d;
        end
    end

    // Next-state logic. HUNT slides bit by bit looking for the comma; once
    // found, the bit counter restarts so every 8th following bit is a byte
    // boundary. CHECK insists on consecutive commas at those boundaries
    // before trusting the alignment.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q + 3'd1;
        commaCnt_d = commaCnt_q;
        case (state_q)
            HUNT: begin
                if (windowIsComma) begin
                    bitCnt_d   = 3'd0;
                    commaCnt_d = 8'd1;
                    if (LOCK_COMMAS <= 1) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (byteDone) begin
                    if (windowIsComma) begin
                        commaCnt_d = commaCnt_q + 8'd1;
                        if (commaCnt_d >= 8'(LOCK_COMMAS)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (dropLock_i) begin
                    state_d = HUNT;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // Byte strobe: raised on the edge that completes a byte while locked.
    // It is held (not cleared) while disabled so a byte finishing just before
    // enb_i drops is still handed to the top level when enb_i returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b0;
        end else if (enb_i) begin
            strobe_q <= (state_q == LOCKED) && byteDone && !dropLock_i;
        end
    end

    // Outputs. Right after a byte-completing edge the shifter holds exactly
    // that byte, and it stays there until the next enabled edge consumes it.
    always_comb begin
        locked_o     = (state_q == LOCKED);
        byteStrobe_o = strobe_q;
        rxByte_o     = shift_q;
        isComma_o    = (shift_q == COMMA);
    end

endmodule

// File: rtl/receptor_serial.sv
// receptor_serial
// Receive side of the serial link: aligns on the comma byte, deserialises
// MSB-first bytes, flags commas as K symbols and re-packs data bytes into
// 8/16/32-bit words.
//   clk, rst  - clock (one serial bit per edge), synchronous active-high reset
//   bus       - receptor_serial_if.slave: enb, serialIn, dataS in;
//               locked, K, dataOut, valid8, dataOut16, valid16,
//               dataOut32, valid32 out
module receptor_serial
    import receptor_serial_pkg::*;
#(
    parameter logic [7:0] COMMA       = receptor_serial_pkg::COMMA,
    parameter int         LOCK_COMMAS = 2,
    parameter int         MAX_GAP     = 64
) (
    input  logic        clk,
    input  logic        rst,
    receptor_serial_if.slave bus
);

    localparam int GAP_W = $clog2(MAX_GAP + 1);

    logic [7:0]  rxByte;
    logic        isComma;
    logic        byteStrobe;
    logic        alignLocked;
    logic        dropLock;
    logic        packByte;
    logic        widthChanged;
    logic [1:0]  lastIdx;
    data_width_e width, widthPrev_q;

    logic             locked_q;
    logic [7:0]       dataOut_q;
    logic             K_q;
    logic             valid8_q;
    logic [15:0]      word16_q;
    logic             valid16_q;
    logic [31:0]      word32_q;
    logic             valid32_q;
    logic [GAP_W-1:0] gap_q;
    logic [1:0]       index_q;
    logic [23:0]      acc_q;

    alinea_byte #(
        .COMMA       (COMMA),
        .LOCK_COMMAS (LOCK_COMMAS)
    ) u_alinea (
        .clk          (clk),
        .rst          (rst),
        .enb_i        (bus.enb),
        .serial_i     (bus.serialIn),
        .dropLock_i   (dropLock),
        .rxByte_o     (rxByte),
        .isComma_o    (isComma),
        .byteStrobe_o (byteStrobe),
        .locked_o     (alignLocked)
    );

    // Width decode plus the events that steer the packer and gap counter.
    // The data byte that brings the gap counter to MAX_GAP is what drops lock.
    always_comb begin
        width        = data_width_e'(bus.dataS);
        lastIdx      = lastIndex(width);
        widthChanged = (width != widthPrev_q);
        packByte     = byteStrobe && !isComma && (lastIdx != 2'd0);
        dropLock     = byteStrobe && !isComma && (gap_q == GAP_W'(MAX_GAP - 1));
    end

    // Output registers, gap counter and word packer. Bytes are shifted into
    // a 24-bit accumulator so that whichever byte finishes a word, the earlier
    // bytes sit in its upper bits in arrival order. A comma, a lock drop or a
    // dataS change throws away the partial word; on a dataS change the byte
    // consumed on that same edge is not packed either. While disabled the
    // strobes are cleared so nothing repeats when enb comes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q    <= 1'b0;
            dataOut_q   <= 8'h00;
            K_q         <= 1'b0;
            valid8_q    <= 1'b0;
            word16_q    <= 16'h0000;
            valid16_q   <= 1'b0;
            word32_q    <= 32'h0000_0000;
            valid32_q   <= 1'b0;
            gap_q       <= '0;
            index_q     <= 2'd0;
            acc_q       <= 24'h00_0000;
            widthPrev_q <= WIDTH_8;
        end else if (bus.enb) begin
            widthPrev_q <= width;
            locked_q    <= alignLocked && !dropLock;
            valid8_q    <= byteStrobe;
            valid16_q   <= 1'b0;
            valid32_q   <= 1'b0;

            if (byteStrobe) begin
                dataOut_q <= rxByte;
                K_q       <= isComma;
                if (isComma || dropLock) begin
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_q + GAP_W'(1);
                end
            end

            if (widthChanged || dropLock || (byteStrobe && isComma)) begin
                index_q <= 2'd0;
            end else if (packByte) begin
                acc_q <= {acc_q[15:0], rxByte};
                if (index_q == lastIdx) begin
                    index_q <= 2'd0;
                    if (width == WIDTH_16) begin
                        word16_q  <= {acc_q[7:0], rxByte};
                        valid16_q <= 1'b1;
                    end else begin
                        word32_q  <= {acc_q, rxByte};
                        valid32_q <= 1'b1;
                    end
                end else begin
                    index_q <= index_q + 2'd1;
                end
            end
        end else begin
            valid8_q  <= 1'b0;
            valid16_q <= 1'b0;
            valid32_q <= 1'b0;
        end
    end

    // Drive the interface; strobes are additionally masked by enb so they
    // read 0 for the whole time the block is disabled.
    always_comb begin
        bus.locked    = locked_q;
        bus.K         = K_q;
        bus.dataOut   = dataOut_q;
        bus.valid8    = valid8_q && bus.enb;
        bus.dataOut16 = word16_q;
        bus.valid16   = valid16_q && bus.enb;
        bus.dataOut32 = word32_q;
        bus.valid32   = valid32_q && bus.enb;
    end

endmodule

// File: tb/tb_receptor_serial.sv
// tb_receptor_serial
// Directed bench for receptor_serial: drives MSB-first bytes, pushes the
// expected bytes/words into scoreboard queues as they are sent, and a monitor
// on the falling edge pops and compares whenever a strobe appears.
module tb_receptor_serial;

    localparam int MAX_GAP = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    receptor_serial_if bus();

    receptor_serial #(
        .COMMA       (8'hBC),
        .LOCK_COMMAS (2),
        .MAX_GAP     (MAX_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0]  exp8Q[$];
    logic [15:0] exp16Q[$];
    logic [31:0] exp32Q[$];

    int cycle        = 0;
    int lastV8       = -1;
    bit checkSpacing = 1'b0;

    // One comparison: counts it, and on a difference counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one bit; it is sampled on the next rising edge.
    task automatic sendBit(input logic b);
        bus.serialIn = b;
        @(posedge clk);
        #1;
    endtask

    // Send one byte MSB first; if the receiver is expected to output it,
    // record it (K set for the comma) before the first bit goes out.
    task automatic applyStimulus(input logic [7:0] b, input bit emit);
        if (emit) exp8Q.push_back({(b == 8'hBC), b});
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cycle++;
        if (bus.valid8) begin
            if (checkSpacing && lastV8 >= 0)
                checkOutput("valid8 spacing", 32'(cycle - lastV8), 32'd8);
            lastV8 = cycle;
            if (exp8Q.size() == 0)
                checkOutput("valid8 with byte expected", 32'(exp8Q.size() > 0), 32'd1);
            else
                checkOutput("K/dataOut", {23'd0, bus.K, bus.dataOut}, {23'd0, exp8Q.pop_front()});
        end
        if (bus.valid16) begin
            checkOutput("valid16 with valid8", {31'd0, bus.valid8}, 32'd1);
            if (exp16Q.size() == 0)
                checkOutput("valid16 with word expected", 32'(exp16Q.size() > 0), 32'd1);
            else
                checkOutput("dataOut16", {16'd0, bus.dataOut16}, {16'd0, exp16Q.pop_front()});
        end
        if (bus.valid32) begin
            checkOutput("valid32 with valid8", {31'd0, bus.valid8}, 32'd1);
            if (exp32Q.size() == 0)
                checkOutput("valid32 with word expected", 32'(exp32Q.size() > 0), 32'd1);
            else
                checkOutput("dataOut32", bus.dataOut32, exp32Q.pop_front());
        end
        if (!bus.enb)
            checkOutput("strobes while disabled", {29'd0, bus.valid8, bus.valid16, bus.valid32}, 32'd0);
    end

    initial begin
        logic [7:0] commaByte;
        commaByte    = 8'hBC;
        bus.enb      = 1'b1;
        bus.dataS    = 2'b00;
        bus.serialIn = 1'b0;
        rst          = 1'b1;

        // Reset held for 10 clocks with a toggling stream.
        for (int i = 0; i < 10; i++) begin
            bus.serialIn = i[0];
            @(posedge clk);
            #1;
        end
        checkOutput("reset locked", {31'd0, bus.locked}, 32'd0);
        checkOutput("reset valids", {29'd0, bus.valid8, bus.valid16, bus.valid32}, 32'd0);
        checkOutput("reset K/dataOut", {23'd0, bus.K, bus.dataOut}, 32'd0);
        checkOutput("reset dataOut16", {16'd0, bus.dataOut16}, 32'd0);
        checkOutput("reset dataOut32", bus.dataOut32, 32'd0);
        rst = 1'b0;

        // Junk bits, two commas to lock, then four data bytes.
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'hBC, 1'b0);
        checkOutput("locked at last comma bit", {31'd0, bus.locked}, 32'd0);
        checkSpacing = 1'b1;
        exp8Q.push_back({1'b0, 8'h00});
        sendBit(1'b0);
        checkOutput("locked one clk after comma", {31'd0, bus.locked}, 32'd1);
        for (int i = 0; i < 7; i++) sendBit(1'b0);
        applyStimulus(8'hCC, 1'b1);
        applyStimulus(8'hAB, 1'b1);
        applyStimulus(8'h25, 1'b1);

        // 16-bit packing with a comma in front.
        bus.dataS = 2'b01;
        exp16Q.push_back(16'hABCD);
        applyStimulus(8'hBC, 1'b1);
        checkSpacing = 1'b0;
        applyStimulus(8'hAB, 1'b1);
        applyStimulus(8'hCD, 1'b1);

        // 32-bit packing; comma mid-word drops the 01 23 partial word.
        applyStimulus(8'hBC, 1'b1);
        bus.dataS = 2'b10;
        exp32Q.push_back(32'h0123_456F);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h23, 1'b1);
        applyStimulus(8'hBC, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h23, 1'b1);
        applyStimulus(8'h45, 1'b1);
        applyStimulus(8'h6F, 1'b1);

        // MAX_GAP data bytes without a comma drop lock.
        applyStimulus(8'hBC, 1'b1);
        bus.dataS = 2'b00;
        applyStimulus(8'hBC, 1'b1);
        for (int i = 0; i < MAX_GAP; i++) applyStimulus(8'(i), 1'b1);
        checkOutput("locked after last gap byte", {31'd0, bus.locked}, 32'd1);
        sendBit(commaByte[7]);
        checkOutput("locked drops at MAX_GAP", {31'd0, bus.locked}, 32'd0);
        for (int i = 6; i >= 0; i--) sendBit(commaByte[i]);
        checkOutput("single comma keeps unlocked", {31'd0, bus.locked}, 32'd0);
        applyStimulus(8'h11, 1'b0);
        checkOutput("data after comma keeps unlocked", {31'd0, bus.locked}, 32'd0);
        applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'hBC, 1'b0);

        // Reset after two data bytes of a 32-bit word, then a clean word.
        bus.dataS = 2'b10;
        applyStimulus(8'h12, 1'b1);
        checkOutput("relocked", {31'd0, bus.locked}, 32'd1);
        applyStimulus(8'h34, 1'b1);
        sendBit(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid reset locked", {31'd0, bus.locked}, 32'd0);
        checkOutput("mid reset K/dataOut", {23'd0, bus.K, bus.dataOut}, 32'd0);
        checkOutput("mid reset dataOut32", bus.dataOut32, 32'd0);
        rst = 1'b0;
        applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'hBC, 1'b0);
        exp32Q.push_back(32'h0102_0304);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h04, 1'b1);

        // enb low for 16 clocks in the middle of a byte.
        exp32Q.push_back(32'h0506_0708);
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h06, 1'b1);
        exp8Q.push_back({1'b0, 8'h07});
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        bus.enb = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.serialIn = ~i[0];
            @(posedge clk);
            #1;
        end
        checkOutput("locked held while disabled", {31'd0, bus.locked}, 32'd1);
        bus.enb = 1'b1;
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b1);
        applyStimulus(8'h08, 1'b1);
        applyStimulus(8'hBC, 1'b1);
        for (int i = 0; i < 4; i++) sendBit(1'b0);

        checkOutput("pending bytes", 32'(exp8Q.size()), 32'd0);
        checkOutput("pending halfwords", 32'(exp16Q.size()), 32'd0);
        checkOutput("pending words", 32'(exp32Q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
